jedro_1_alu_arbiter: RTL

- Shares the single registered ALU between two requesters: req0 is the execute stage, req1 is the load/store address generator.
- Arbitrates issue with a valid/ready handshake and drives the ALU operand, select and pass-through inputs.
- Tags each issued operation and steers the ALU's registered outputs into a per-requester 2-entry response FIFO with valid/ready.
- Sits between the decoder/LSU and the ALU instance.

---
 rtl/jedro_1_alu_arbiter_pkg.sv | 39 +++
 rtl/jedro_1_alu_rsp_fifo.sv | 55 +++++
 rtl/jedro_1_alu_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jedro_1_alu_arbiter_pkg.sv
// Shared widths, ALU opcodes and response-entry type for the jedro_1 ALU arbiter.
// The arbitration helper lives here so the tie-break rule exists in one place.
package jedro_1_alu_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_OP_W   = 4;
  localparam int REG_ADDR_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'b1101;

  typedef struct packed {
    logic [XLEN-1:0]       res;
    logic                  eq;
    logic                  ovf;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb;
  } alu_rsp_t;

  // One-hot grant from the eligible mask; on a tie the requester that did not
  // win last time takes it, unless fixed priority pins the tie to req0.
  function automatic logic [1:0] arb_grant(input logic [1:0] elig,
                                           input logic       last,
                                           input logic       fixed_prio);
    arb_grant = elig;
    if (elig == 2'b11) begin
      arb_grant = (fixed_prio || last) ? 2'b01 : 2'b10;
    end
  endfunction

endpackage

// File: rtl/jedro_1_alu_rsp_fifo.sv
// Two-entry response FIFO; head entry is presented combinationally on data_o.
module jedro_1_alu_rsp_fifo
  import jedro_1_alu_arbiter_pkg::*;
#(
  parameter type T = alu_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  T           data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output T           data_o,
  output logic [1:0] occ_o
);

  T           mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic       wr_en, rd_en;

  assign wr_en = push_i && (occ_q != 2'd2);
  assign rd_en = pop_i && (occ_q != 2'd0);

  always_comb begin
    rd_ptr_d = rd_en ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = wr_en ? ~wr_ptr_q : wr_ptr_q;
    occ_d    = occ_q + {1'b0, wr_en} - {1'b0, rd_en};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/jedro_1_alu_arbiter.sv
// Shares one registered ALU between the execute stage (req0) and the LSU address
// generator (req1); results return through a 2-entry FIFO per requester.
module jedro_1_alu_arbiter
  import jedro_1_alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [ALU_OP_W-1:0]   req0_sel_i,
  input  logic [DATA_WIDTH-1:0] req0_op_a_i,
  input  logic [DATA_WIDTH-1:0] req0_op_b_i,
  input  logic [REG_ADDR_W-1:0] req0_dest_addr_i,
  input  logic                  req0_wb_i,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [ALU_OP_W-1:0]   req1_sel_i,
  input  logic [DATA_WIDTH-1:0] req1_op_a_i,
  input  logic [DATA_WIDTH-1:0] req1_op_b_i,
  input  logic [REG_ADDR_W-1:0] req1_dest_addr_i,
  input  logic                  req1_wb_i,

  output logic [ALU_OP_W-1:0]   alu_sel_o,
  output logic [DATA_WIDTH-1:0] alu_op_a_o,
  output logic [DATA_WIDTH-1:0] alu_op_b_o,
  output logic [REG_ADDR_W-1:0] alu_dest_addr_o,
  output logic                  alu_wb_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  alu_ops_eq_i,
  input  logic                  alu_overflow_i,
  input  logic [REG_ADDR_W-1:0] alu_dest_addr_i,
  input  logic                  alu_wb_i,

  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_res_o,
  output logic                  rsp0_eq_o,
  output logic                  rsp0_ovf_o,
  output logic [REG_ADDR_W-1:0] rsp0_dest_addr_o,
  output logic                  rsp0_wb_o,

  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_res_o,
  output logic                  rsp1_eq_o,
  output logic                  rsp1_ovf_o,
  output logic [REG_ADDR_W-1:0] rsp1_dest_addr_o,
  output logic                  rsp1_wb_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] res;
    logic                  eq;
    logic                  ovf;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb;
  } rsp_t;

  logic       inflight_q, inflight_d;
  logic       inflight_tag_q, inflight_tag_d;
  logic       last_q, last_d;

  logic [1:0] req_valid, rsp_ready, rsp_valid;
  logic [1:0] elig, grant, push, pop;
  logic [1:0] occ [2];
  rsp_t       alu_rsp;
  rsp_t       rsp_head [2];

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign alu_rsp   = '{res: alu_res_i, eq: alu_ops_eq_i, ovf: alu_overflow_i,
                       dest: alu_dest_addr_i, wb: alu_wb_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic       fifo_valid;
      logic [2:0] fill;

      // The in-flight op for this requester lands in its FIFO this cycle.
      assign push[gi] = inflight_q && (inflight_tag_q == 1'(gi));

      jedro_1_alu_rsp_fifo #(.T(rsp_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push[gi]),
        .data_i  (alu_rsp),
        .pop_i   (pop[gi]),
        .valid_o (fifo_valid),
        .data_o  (rsp_head[gi]),
        .occ_o   (occ[gi])
      );

      assign rsp_valid[gi] = fifo_valid && !rst_i;
      assign pop[gi]       = rsp_valid[gi] && rsp_ready[gi];
      // Occupancy after this cycle's push/pop must leave room for a new issue.
      assign fill          = {1'b0, occ[gi]} + {2'b00, push[gi]} - {2'b00, pop[gi]};
      assign elig[gi]      = req_valid[gi] && !rst_i && (fill < 3'd2);
    end
  endgenerate

  assign grant        = arb_grant(elig, last_q, FIXED_PRIO);
  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    alu_sel_o       = ALU_OP_ADD;
    alu_op_a_o      = '0;
    alu_op_b_o      = '0;
    alu_dest_addr_o = '0;
    alu_wb_o        = 1'b0;
    if (grant[0]) begin
      alu_sel_o       = req0_sel_i;
      alu_op_a_o      = req0_op_a_i;
      alu_op_b_o      = req0_op_b_i;
      alu_dest_addr_o = req0_dest_addr_i;
      alu_wb_o        = req0_wb_i;
    end else if (grant[1]) begin
      alu_sel_o       = req1_sel_i;
      alu_op_a_o      = req1_op_a_i;
      alu_op_b_o      = req1_op_b_i;
      alu_dest_addr_o = req1_dest_addr_i;
      alu_wb_o        = req1_wb_i;
    end
  end

  always_comb begin
    inflight_d     = |grant;
    inflight_tag_d = grant[1];
    last_d         = (|grant) ? grant[1] : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q     <= 1'b0;
      inflight_tag_q <= 1'b0;
      last_q         <= 1'b1;
    end else begin
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      last_q         <= last_d;
    end
  end

  assign rsp0_valid_o     = rsp_valid[0];
  assign rsp0_res_o       = rsp_head[0].res;
  assign rsp0_eq_o        = rsp_head[0].eq;
  assign rsp0_ovf_o       = rsp_head[0].ovf;
  assign rsp0_dest_addr_o = rsp_head[0].dest;
  assign rsp0_wb_o        = rsp_head[0].wb;

  assign rsp1_valid_o     = rsp_valid[1];
  assign rsp1_res_o       = rsp_head[1].res;
  assign rsp1_eq_o        = rsp_head[1].eq;
  assign rsp1_ovf_o       = rsp_head[1].ovf;
  assign rsp1_dest_addr_o = rsp_head[1].dest;
  assign rsp1_wb_o        = rsp_head[1].wb;

endmodule
